wav_stream_parser: RTL and testbench
====================================

// Module: wav_stream_parser
// PURPOSE
//  Parses a RIFF/WAVE file from the raw SD sector byte stream (sd_read byte/valid output).
//  Extracts the fmt fields, skips unknown chunks, then emits 16-bit little-endian PCM samples.
//  Sits between sd_read and the ram_rw_control sample buffer; replaces blind header skipping.
// PARAMETERS
//  FMT_MIN_LEN   16  minimum legal fmt chunk size; smaller -> error
//  ALLOW_MONO    1   1: num_channels 1 or 2 accepted; 0: only 2 accepted
// PORTS
//  clk             in   1   single clock; all logic rising-edge
//  rst             in   1   asynchronous, active-high reset
//  start           in   1   1-cycle pulse: begin parse at first byte of file (aborts any parse)
//  byte_data       in   8   byte from SD read path
//  byte_valid      in   1   byte_data qualifier; always accepted, no backpressure
//  busy            out  1   parse in progress (start seen, not yet done/error)
//  hdr_valid       out  1   fmt fields latched and legal; held until start/rst
//  sample_rate     out  32  fmt SampleRate
//  num_channels    out  16  fmt NumChannels
//  data_bytes      out  32  data chunk size field
//  sample_data     out  16  PCM sample, {byte1,byte0}
//  sample_valid    out  1   1-cycle strobe per sample
//  done            out  1   data chunk fully consumed; held until start/rst
//  error           out  1   malformed/unsupported file; held until start/rst
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, counters 0. start: same clearing, FSM -> RIFF_ID.
//  byte_valid outside busy ignored. start in the same cycle as byte_valid: byte dropped, start wins.
//  States (one byte consumed per valid cycle):
//   IDLE     wait start
//   RIFF_ID  4 bytes must be "RIFF" else ERROR at first mismatching byte
//   RIFF_SZ  4 bytes, value ignored
//   FORM     4 bytes must be "WAVE" else ERROR
//   CK_ID    4-byte chunk id shifted into id reg
//   CK_SZ    4-byte LE size into rem counter; then dispatch on id:
//            "fmt " -> FMT; "data" -> DATA (data_bytes<=size, hdr_valid must be 1 else ERROR);
//            other -> SKIP. size 0 -> straight back to CK_ID (pad rule still applies)
//   FMT      byte offsets 0-1 AudioFormat (must be 1), 2-3 channels, 4-7 rate,
//            14-15 bits (must be 16); size<FMT_MIN_LEN -> ERROR; bytes beyond 16 discarded;
//            at end: checks pass -> hdr_valid=1 same cycle as last fmt byte consumed +1
//   SKIP     discard rem bytes; odd size -> one extra pad byte discarded (fmt, skip alike)
//   DATA     pair bytes: low byte held, high byte completes; sample_valid rises the cycle after
//            the high byte is accepted (latency 1); rem decrements per byte;
//            rem reaches 0 -> done=1 next cycle, FSM IDLE; odd size: final lone byte dropped
//   ERROR    sticky error=1, busy=0, all further bytes ignored until start/rst
//  Second "fmt " chunk overwrites fields; second "data" not reached (parse ends at first).
//  rem is 32-bit; no wrap: 0xFFFFFFFF size streams until start/rst.
//  Reset or start mid-DATA: no further sample_valid, partial sample discarded.
//  hdr_valid, sample_rate, num_channels stable throughout DATA.
// STRUCTURE
//  Include file wav_defs.vh: state encodings, ID constants "RIFF" 32'h46464952,
//  "WAVE" 32'h45564157, "fmt " 32'h20746D66, "data" 32'h61746164 (LE-packed), PCM_FMT=1.
//  Single module, no sub-modules; one 32-bit LE shift register shared by id/size/field capture.
// TESTING
//  1 canonical 44-byte header, 44100 Hz, 2 ch, 16 bit, data size 8, bytes 01..08
//    -> hdr_valid, rate=44100, ch=2, samples 0x0201,0x0403,0x0605,0x0807, done.
//  2 "LIST" chunk size 26 plus "junk" size 5 (+pad) before "fmt "/"data" -> same fields and samples as 1.
//  3 fmt bits=8 -> error=1, hdr_valid=0, no sample_valid, busy=0.
//  4 "RIFX" first id -> error asserted after 4th byte; later bytes ignored.
//  5 data size 3 -> one sample then done; third byte produces no strobe.
//  6 start pulse after 2 samples of DATA, then file of test 1 -> outputs cleared, full reparse matches 1;
//    repeat with rst instead of start -> all outputs 0 while rst high.

Source files
------------

// File: rtl/wav_stream_parser_pkg.sv
// Shared definitions for the RIFF/WAVE stream parser: parser states, chunk IDs
// packed little-endian exactly as they arrive on the byte stream, and PCM constants.
package wav_stream_parser_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RIFF_ID,
        ST_RIFF_SZ,
        ST_FORM,
        ST_CK_ID,
        ST_CK_SZ,
        ST_FMT,
        ST_SKIP,
        ST_PAD,
        ST_DATA,
        ST_ERROR
    } state_t;

    localparam logic [31:0] ID_RIFF  = 32'h46464952;
    localparam logic [31:0] ID_WAVE  = 32'h45564157;
    localparam logic [31:0] ID_FMT   = 32'h20746D66;
    localparam logic [31:0] ID_DATA  = 32'h61746164;
    localparam logic [15:0] PCM_FMT  = 16'd1;
    localparam logic [15:0] PCM_BITS = 16'd16;

    function automatic logic [7:0] id_byte(input logic [31:0] id, input logic [1:0] idx);
        return id[8*idx +: 8];
    endfunction

endpackage

// File: rtl/wav_stream_parser.sv
// RIFF/WAVE parser between the SD byte stream and the sample buffer: validates the
// header, captures the fmt fields, skips unknown chunks and emits 16-bit PCM samples.
module wav_stream_parser
    import wav_stream_parser_pkg::*;
#(
    parameter int FMT_MIN_LEN = 16,
    parameter bit ALLOW_MONO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        busy,
    output logic        hdr_valid,
    output logic [31:0] sample_rate,
    output logic [15:0] num_channels,
    output logic [31:0] data_bytes,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic        done,
    output logic        error
);

    state_t      state, next_state;
    logic [23:0] sh;
    logic [31:0] ck_id;
    logic [31:0] rem;
    logic [1:0]  cnt;
    logic [4:0]  off;
    logic        odd;
    logic        phase;
    logic [15:0] fmt_audio, fmt_ch, fmt_bits;
    logic [31:0] fmt_rate;

    logic [31:0] word;
    logic [15:0] half;
    logic [15:0] bits_now;
    logic        accept, last_byte, ch_ok, fmt_ok, size_short;

    // word is the 32-bit LE value completed by the current byte; half the 16-bit one.
    assign word       = {byte_data, sh};
    assign half       = {byte_data, sh[23:16]};
    assign busy       = (state != ST_IDLE) && (state != ST_ERROR);
    assign accept     = byte_valid && busy && !start;
    assign last_byte  = (rem == 32'd1);
    assign bits_now   = (off == 5'd15) ? half : fmt_bits;
    assign ch_ok      = (fmt_ch == 16'd2) || (ALLOW_MONO && (fmt_ch == 16'd1));
    assign fmt_ok     = (fmt_audio == PCM_FMT) && (bits_now == PCM_BITS) && ch_ok;
    assign size_short = word < 32'(FMT_MIN_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state is assigned before the case so every path has a value; no latch is inferred.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_RIFF_ID;
        end else if (accept) begin
            case (state)
                ST_RIFF_ID: begin
                    if (byte_data != id_byte(ID_RIFF, cnt)) next_state = ST_ERROR;
                    else if (cnt == 2'd3)                   next_state = ST_RIFF_SZ;
                end
                ST_RIFF_SZ: if (cnt == 2'd3) next_state = ST_FORM;
                ST_FORM: begin
                    if (byte_data != id_byte(ID_WAVE, cnt)) next_state = ST_ERROR;
                    else if (cnt == 2'd3)                   next_state = ST_CK_ID;
                end
                ST_CK_ID: if (cnt == 2'd3) next_state = ST_CK_SZ;
                ST_CK_SZ: begin
                    if (cnt == 2'd3) begin
                        if (ck_id == ID_FMT)       next_state = size_short ? ST_ERROR : ST_FMT;
                        else if (ck_id == ID_DATA) begin
                            if (!hdr_valid)           next_state = ST_ERROR;
                            else if (word == 32'd0)   next_state = ST_IDLE;
                            else                      next_state = ST_DATA;
                        end
                        else if (word == 32'd0)    next_state = ST_CK_ID;
                        else                       next_state = ST_SKIP;
                    end
                end
                ST_FMT: begin
                    if (last_byte) begin
                        if (!fmt_ok)  next_state = ST_ERROR;
                        else if (odd) next_state = ST_PAD;
                        else          next_state = ST_CK_ID;
                    end
                end
                ST_SKIP: if (last_byte) next_state = odd ? ST_PAD : ST_CK_ID;
                ST_PAD:  next_state = ST_CK_ID;
                ST_DATA: if (last_byte) next_state = ST_IDLE;
                default: ;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh <= '0; ck_id <= '0; rem <= '0; cnt <= '0; off <= '0; odd <= 1'b0; phase <= 1'b0;
            fmt_audio <= '0; fmt_ch <= '0; fmt_bits <= '0; fmt_rate <= '0;
            hdr_valid <= 1'b0; sample_rate <= '0; num_channels <= '0; data_bytes <= '0;
            sample_data <= '0; sample_valid <= 1'b0; done <= 1'b0; error <= 1'b0;
        end else if (start) begin
            sh <= '0; ck_id <= '0; rem <= '0; cnt <= '0; off <= '0; odd <= 1'b0; phase <= 1'b0;
            fmt_audio <= '0; fmt_ch <= '0; fmt_bits <= '0; fmt_rate <= '0;
            hdr_valid <= 1'b0; sample_rate <= '0; num_channels <= '0; data_bytes <= '0;
            sample_data <= '0; sample_valid <= 1'b0; done <= 1'b0; error <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (accept) begin
                sh <= word[31:8];
                if (state inside {ST_RIFF_ID, ST_RIFF_SZ, ST_FORM, ST_CK_ID, ST_CK_SZ})
                    cnt <= cnt + 2'd1;
                if (next_state == ST_ERROR)
                    error <= 1'b1;
                case (state)
                    ST_CK_ID: if (cnt == 2'd3) ck_id <= word;
                    ST_CK_SZ: begin
                        if (cnt == 2'd3) begin
                            rem   <= word;
                            odd   <= word[0];
                            off   <= '0;
                            phase <= 1'b0;
                            if ((ck_id == ID_DATA) && hdr_valid) begin
                                data_bytes <= word;
                                if (word == 32'd0) done <= 1'b1;
                            end
                        end
                    end
                    ST_FMT: begin
                        rem <= rem - 32'd1;
                        if (off != 5'd16) off <= off + 5'd1;
                        case (off)
                            5'd1:    fmt_audio <= half;
                            5'd3:    fmt_ch    <= half;
                            5'd7:    fmt_rate  <= word;
                            5'd15:   fmt_bits  <= half;
                            default: ;
                        endcase
                        // Outputs only change once a whole fmt chunk has been validated.
                        if (last_byte && fmt_ok) begin
                            hdr_valid    <= 1'b1;
                            sample_rate  <= fmt_rate;
                            num_channels <= fmt_ch;
                        end
                    end
                    ST_SKIP: rem <= rem - 32'd1;
                    ST_DATA: begin
                        rem   <= rem - 32'd1;
                        phase <= ~phase;
                        if (phase) begin
                            sample_data  <= half;
                            sample_valid <= 1'b1;
                        end
                        if (last_byte) done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wav_stream_parser.sv
// Self-checking bench: directed WAV files plus randomized chunk layouts, compared
// against a software-style RIFF parser model over the same byte array.
module tb_wav_stream_parser;

    localparam logic [31:0] K_RIFF = 32'h46464952;
    localparam logic [31:0] K_WAVE = 32'h45564157;
    localparam logic [31:0] K_FMT  = 32'h20746D66;
    localparam logic [31:0] K_DATA = 32'h61746164;
    localparam logic [31:0] K_LIST = 32'h5453494C;
    localparam logic [31:0] K_JUNK = 32'h6B6E756A;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        busy, hdr_valid, sample_valid, done, error;
    logic [31:0] sample_rate, data_bytes;
    logic [15:0] num_channels, sample_data;

    wav_stream_parser dut (
        .clk(clk), .rst(rst), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
        .busy(busy), .hdr_valid(hdr_valid), .sample_rate(sample_rate), .num_channels(num_channels),
        .data_bytes(data_bytes), .sample_data(sample_data), .sample_valid(sample_valid),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  fq[$];
    logic [15:0] got[$];
    logic [15:0] e_samp[$];
    logic        e_err, e_hv, e_done;
    logic [31:0] e_rate, e_db;
    logic [15:0] e_ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            got.push_back(sample_data);
            check("hv_at_sample", {31'd0, hdr_valid}, 32'd1);
        end
    end

    task automatic put8(input logic [7:0] b);   fq.push_back(b); endtask
    task automatic put16(input logic [15:0] v); put8(v[7:0]); put8(v[15:8]); endtask
    task automatic put32(input logic [31:0] v); put16(v[15:0]); put16(v[31:16]); endtask

    function automatic logic [7:0] rd8(input int i);
        return (i < fq.size()) ? fq[i] : 8'h00;
    endfunction
    function automatic logic [15:0] rd16(input int i);
        return {rd8(i + 1), rd8(i)};
    endfunction
    function automatic logic [31:0] rd32(input int i);
        return {rd16(i + 2), rd16(i)};
    endfunction

    // Walks the file like a software WAV reader and records what the parser should report.
    task automatic run_model();
        int p;
        logic [31:0] id, sz;
        e_err = 0; e_hv = 0; e_done = 0; e_rate = 0; e_ch = 0; e_db = 0;
        e_samp.delete();
        if (rd32(0) != K_RIFF || rd32(8) != K_WAVE) begin e_err = 1; return; end
        p = 12;
        while (p + 8 <= fq.size()) begin
            id = rd32(p);
            sz = rd32(p + 4);
            p += 8;
            if (id == K_FMT) begin
                if (sz < 16) begin e_err = 1; return; end
                if (rd16(p) == 16'd1 && rd16(p + 14) == 16'd16 &&
                    (rd16(p + 2) == 16'd1 || rd16(p + 2) == 16'd2)) begin
                    e_hv = 1; e_ch = rd16(p + 2); e_rate = rd32(p + 4);
                end else begin
                    e_err = 1; return;
                end
            end else if (id == K_DATA) begin
                if (!e_hv) begin e_err = 1; return; end
                e_db = sz;
                for (int k = 0; k < int'(sz / 2); k++) e_samp.push_back(rd16(p + 2 * k));
                e_done = 1;
                return;
            end
            p += int'(sz) + int'(sz[0]);
        end
    endtask

    task automatic build_file(input logic [15:0] bits, input int ds, input bit extra);
        fq.delete();
        put32(K_RIFF); put32(32'(36 + ds)); put32(K_WAVE);
        if (extra) begin
            put32(K_LIST); put32(32'd26);
            for (int i = 0; i < 26; i++) put8(8'($urandom));
            put32(K_JUNK); put32(32'd5);
            for (int i = 0; i < 6; i++) put8(8'($urandom));
        end
        put32(K_FMT); put32(32'd16); put16(16'd1); put16(16'd2); put32(32'd44100);
        put32(32'd44100 * 32'(bits) / 4); put16(bits / 4); put16(bits);
        put32(K_DATA); put32(32'(ds));
        for (int i = 0; i < ds; i++) put8(8'(i + 1));
    endtask

    task automatic put_unknown();
        int sz;
        put32({8'($urandom_range(65, 90)), 8'($urandom_range(65, 90)), 8'($urandom_range(65, 90)), 8'h78});
        sz = int'($urandom_range(0, 9));
        put32(32'(sz));
        for (int i = 0; i < sz + (sz % 2); i++) put8(8'($urandom));
    endtask

    task automatic gen_random();
        int fsz, ds, idx;
        logic [15:0] ch, au, bt;
        logic [31:0] rate;
        fq.delete();
        put32(K_RIFF); put32($urandom); put32(K_WAVE);
        for (int u = 0; u < int'($urandom_range(0, 2)); u++) put_unknown();
        if ($urandom_range(0, 7) != 0) begin
            fsz  = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(16, 19));
            au   = ($urandom_range(0, 7) == 0) ? 16'd3 : 16'd1;
            ch   = 16'($urandom_range(1, 3));
            rate = $urandom;
            bt   = ($urandom_range(0, 5) == 0) ? 16'd8 : 16'd16;
            put32(K_FMT); put32(32'(fsz)); put16(au); put16(ch); put32(rate);
            put32(rate * 32'(ch) * 2); put16(ch * 16'd2); put16(bt);
            for (int i = 16; i < fsz + (fsz % 2); i++) put8(8'($urandom));
        end
        if ($urandom_range(0, 1) != 0) put_unknown();
        ds = int'($urandom_range(0, 12));
        put32(K_DATA); put32(32'(ds));
        for (int i = 0; i < ds; i++) put8(8'($urandom));
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) put8(8'($urandom));
        if ($urandom_range(0, 9) == 0) begin
            idx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(8, 11));
            fq[idx] = fq[idx] ^ 8'($urandom_range(1, 255));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_byte(fq[i]);
    endtask

    task automatic pulse_start(input bit with_byte);
        start      = 1'b1;
        byte_valid = with_byte;
        byte_data  = 8'h52;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        got.delete();
    endtask

    task automatic compare(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
        check({tag, "_hdr_valid"}, {31'd0, hdr_valid}, {31'd0, e_hv});
        check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, !(e_err || e_done)});
        check({tag, "_rate"}, sample_rate, e_rate);
        check({tag, "_chans"}, {16'd0, num_channels}, {16'd0, e_ch});
        check({tag, "_data_bytes"}, data_bytes, e_db);
        check({tag, "_nsamp"}, got.size(), e_samp.size());
        for (int i = 0; i < e_samp.size() && i < got.size(); i++)
            check({tag, "_sample"}, {16'd0, got[i]}, {16'd0, e_samp[i]});
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
        check({tag, "_hdr_valid"}, {31'd0, hdr_valid}, 32'd0);
        check({tag, "_rate"}, sample_rate, 32'd0);
        check({tag, "_chans"}, {16'd0, num_channels}, 32'd0);
        check({tag, "_data_bytes"}, data_bytes, 32'd0);
        check({tag, "_sample_data"}, {16'd0, sample_data}, 32'd0);
        check({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Canonical file; start coincides with a byte that must be dropped.
        build_file(16'd16, 8, 1'b0); run_model();
        pulse_start(1'b1); send_range(0, fq.size()); compare("t1");
        check("t1_rate_abs", sample_rate, 32'd44100);
        check("t1_chans_abs", {16'd0, num_channels}, 32'd2);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check("t1_sample_abs", {16'd0, got[i]}, {16'd0, 8'(2 * i + 2), 8'(2 * i + 1)});

        build_file(16'd16, 8, 1'b1); run_model();
        pulse_start(1'b0); send_range(0, fq.size()); compare("t2");

        build_file(16'd8, 8, 1'b0); run_model();
        pulse_start(1'b0); send_range(0, fq.size()); compare("t3");

        build_file(16'd16, 8, 1'b0); fq[3] = 8'h58; run_model();
        pulse_start(1'b0); send_range(0, 3);
        check("t4_err_before", {31'd0, error}, 32'd0);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        send_range(3, 4);
        check("t4_err_at_4", {31'd0, error}, 32'd1);
        check("t4_busy_at_4", {31'd0, busy}, 32'd0);
        send_range(4, fq.size()); compare("t4");

        build_file(16'd16, 3, 1'b0); run_model();
        pulse_start(1'b0); send_range(0, fq.size()); compare("t5");

        // Abort by start in the middle of DATA, then reparse cleanly.
        build_file(16'd16, 8, 1'b0); run_model();
        pulse_start(1'b0); send_range(0, 48);
        pulse_start(1'b1);
        check_outputs("t6_start", 1'b1);
        repeat (3) @(negedge clk);
        check("t6_no_strobe", got.size(), 32'd0);
        pulse_start(1'b0); send_range(0, fq.size()); compare("t6a");

        // Abort by reset in the middle of DATA.
        pulse_start(1'b0); send_range(0, 48);
        rst = 1'b1;
        #1;
        check_outputs("t6_rst_async", 1'b0);
        repeat (2) @(negedge clk);
        check_outputs("t6_rst_held", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(1'b0); send_range(0, fq.size()); compare("t6b");

        repeat (40) begin
            gen_random(); run_model();
            pulse_start(1'($urandom_range(0, 1)));
            send_range(0, fq.size());
            compare("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
